control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Instruction-sequencing FSM of the 16-bit processor; sits directly upstream of the program counter.
//  Drives the PC's Clr/Up inputs and the instruction-register load.
//  Decodes the registered instruction and sequences the data memory, register file and ALU controls.
//  Cost: FETCH+DECODE+execute = 3 cycles per instruction; LOAD takes 4.
// PARAMETERS
//  DAW   8   data-memory address width (IR[11:4] for LOAD/STORE)
//  RAW   4   register-file address width
//  ALUW  3   ALU select width
// PORTS
//  Clk        in   1     clock; all state updates on posedge
//  Clr        in   1     asynchronous, active-low reset
//  IR         in   16    current instruction register contents
//  PC_Clr     out  1     to PC Clr; active-low sync clear (0 = clear PC)
//  PC_Up      out  1     to PC Up; increment enable
//  IR_Ld      out  1     load instruction-memory output into IR
//  D_Addr     out  DAW   data-memory address
//  D_Wr       out  1     data-memory write enable
//  RF_s       out  1     RF write-data mux: 1 = data memory, 0 = ALU
//  RF_W_Addr  out  RAW   RF write address
//  RF_W_En    out  1     RF write enable
//  RF_Ra_Addr out  RAW   RF read port A address
//  RF_Rb_Addr out  RAW   RF read port B address
//  ALU_s0     out  ALUW  ALU op select
//  State      out  4     current state encoding (debug/LEDs)
// BEHAVIOUR
//  - Opcode in IR[15:12]:
//    0000 NOOP.
//    0001 STORE: D[IR[11:4]] <= R[IR[3:0]].
//    0010 LOAD: R[IR[3:0]] <= D[IR[11:4]].
//    0011 ADD: R[IR[3:0]] <= R[IR[11:8]] + R[IR[7:4]].
//    0100 SUB: same fields, Ra - Rb.
//    0101 HALT.
//    All other opcodes execute as NOOP.
//  - States: INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, NOOP, HALT.
//  - Clr=0 (any time, mid-instruction included) -> async to INIT; all outputs take defaults.
//    Defaults: PC_Clr=0 in INIT; every other output 0; ALU_s0=000.
//  - Transitions:
//    INIT->FETCH;
//    FETCH->DECODE;
//    DECODE->{NOOP,STORE,LOAD_A,ADD,SUB,HALT} by opcode;
//    LOAD_A->LOAD_B;
//    LOAD_B, STORE, ADD, SUB, NOOP -> FETCH;
//    HALT->HALT until Clr.
//  - Outputs are Moore, decoded from state and IR only:
//    INIT   PC_Clr=0.
//    FETCH  IR_Ld=1, PC_Up=1 for exactly one cycle (PC advances once per instruction).
//    DECODE all enables 0.
//    STORE  D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0], D_Wr=1.
//    LOAD_A D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0], RF_W_En=0 (memory read latency).
//    LOAD_B same as LOAD_A, with RF_W_En=1.
//    ADD    Ra=IR[11:8], Rb=IR[7:4], RF_W_Addr=IR[3:0], RF_W_En=1, RF_s=0, ALU_s0=001.
//    SUB    as ADD with ALU_s0=010.
//  - PC_Clr=1 in every state except INIT.
//  - HALT: all enables 0, PC frozen. No wrap concern: a PC wrap 127->0 is a PC property.
//  - Never: D_Wr and RF_W_En high in the same cycle; PC_Up high outside FETCH.
// STRUCTURE
//  - cpu_pkg holds:
//    state_t enum (4-bit encoding exported on State);
//    opcode localparams OP_NOOP..OP_HALT;
//    ALU select constants ALU_PASS=000, ALU_ADD=001, ALU_SUB=010.
//  - Sub-module instr_fields: combinational split of IR into op/daddr/ra/rb/rw, shared with the datapath.
//  - Body: state register (async reset), next-state case, output case with defaults first.
// TESTING
//  1. Clr=0 mid-ADD, then released.
//     -> INIT; PC_Clr=0, all enables 0; FETCH on the next edge.
//  2. IR=16'h2A35 (LOAD).
//     -> FETCH, DECODE, LOAD_A, LOAD_B.
//     -> D_Addr=8'hA3 and RF_W_Addr=5 in both LOAD states; RF_W_En only in LOAD_B; RF_s=1.
//  3. IR=16'h112F (STORE).
//     -> STORE state: D_Addr=8'h12, RF_Ra_Addr=F, D_Wr=1 for exactly 1 cycle.
//  4. IR=16'h3126 (ADD), then IR=16'h4126 (SUB).
//     -> Ra=1, Rb=2, RF_W_Addr=6, RF_W_En=1, RF_s=0.
//     -> ALU_s0=001 for ADD, 010 for SUB.
//  5. Hook up the PC and an instruction ROM; run 5 NOOPs then HALT.
//     -> PC_Up pulses once per 3 cycles; PC addr=6 at HALT.
//     -> Stays in HALT with no further PC_Up until Clr.
//  6. IR opcode 4'hF (undefined).
//     -> Behaves as NOOP: no write strobes; returns to FETCH after 3 cycles total.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit processor control path.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_NOOP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit bus: instruction in, PC/IR/data-memory/register-file/ALU controls out.
interface control_unit_if #(
  parameter int unsigned DAW  = 8,
  parameter int unsigned RAW  = 4,
  parameter int unsigned ALUW = 3
);
  logic [15:0]     IR;
  logic            PC_Clr;
  logic            PC_Up;
  logic            IR_Ld;
  logic [DAW-1:0]  D_Addr;
  logic            D_Wr;
  logic            RF_s;
  logic [RAW-1:0]  RF_W_Addr;
  logic            RF_W_En;
  logic [RAW-1:0]  RF_Ra_Addr;
  logic [RAW-1:0]  RF_Rb_Addr;
  logic [ALUW-1:0] ALU_s0;
  logic [3:0]      State;

  modport master (
    input  IR,
    output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State
  );

  modport slave (
    output IR,
    input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State
  );
endinterface

// File: rtl/control_unit_instr_fields.sv
// Combinational split of the instruction word into opcode and operand fields.
module instr_fields #(
  parameter int unsigned DAW = 8,
  parameter int unsigned RAW = 4
) (
  input  logic [15:0]    IR,
  output logic [3:0]     op,
  output logic [DAW-1:0] daddr,
  output logic [RAW-1:0] ra,
  output logic [RAW-1:0] rb,
  output logic [RAW-1:0] rw
);
  // ra/rb overlap daddr: arithmetic and memory formats share IR[11:4].
  assign op    = IR[15:12];
  assign daddr = IR[4 +: DAW];
  assign ra    = IR[8 +: RAW];
  assign rb    = IR[4 +: RAW];
  assign rw    = IR[0 +: RAW];
endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM: FETCH, DECODE, execute; drives PC, IR, memory, RF and ALU controls.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DAW  = 8,
  parameter int unsigned RAW  = 4,
  parameter int unsigned ALUW = 3
) (
  input  logic           Clk,
  input  logic           Clr,
  control_unit_if.master bus
);

  state_t          state, nxt;
  logic [3:0]      op;
  logic [DAW-1:0]  f_daddr;
  logic [RAW-1:0]  f_ra, f_rb, f_rw;

  logic            n_pc_clr, n_pc_up, n_ir_ld, n_d_wr, n_rf_s, n_rf_w_en;
  logic [DAW-1:0]  n_d_addr;
  logic [RAW-1:0]  n_rf_w_addr, n_rf_ra, n_rf_rb;
  logic [ALUW-1:0] n_alu;

  instr_fields #(.DAW(DAW), .RAW(RAW)) u_fields (
    .IR    (bus.IR),
    .op    (op),
    .daddr (f_daddr),
    .ra    (f_ra),
    .rb    (f_rb),
    .rw    (f_rw)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_INIT:   nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_STORE: nxt = S_STORE;
          OP_LOAD:  nxt = S_LOAD_A;
          OP_ADD:   nxt = S_ADD;
          OP_SUB:   nxt = S_SUB;
          OP_HALT:  nxt = S_HALT;
          default:  nxt = S_NOOP;
        endcase
      end
      S_LOAD_A: nxt = S_LOAD_B;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  // Outputs are decoded from the state being entered so they are registered yet
  // still Moore-aligned with State; IR is stable from DECODE onwards.
  always_comb begin
    n_pc_clr    = 1'b1;
    n_pc_up     = 1'b0;
    n_ir_ld     = 1'b0;
    n_d_addr    = '0;
    n_d_wr      = 1'b0;
    n_rf_s      = 1'b0;
    n_rf_w_addr = '0;
    n_rf_w_en   = 1'b0;
    n_rf_ra     = '0;
    n_rf_rb     = '0;
    n_alu       = ALUW'(ALU_PASS);
    case (nxt)
      S_INIT:  n_pc_clr = 1'b0;
      S_FETCH: begin
        n_ir_ld = 1'b1;
        n_pc_up = 1'b1;
      end
      S_STORE: begin
        n_d_addr = f_daddr;
        n_rf_ra  = f_rw;
        n_d_wr   = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        n_d_addr    = f_daddr;
        n_rf_s      = 1'b1;
        n_rf_w_addr = f_rw;
        n_rf_w_en   = (nxt == S_LOAD_B);
      end
      S_ADD, S_SUB: begin
        n_rf_ra     = f_ra;
        n_rf_rb     = f_rb;
        n_rf_w_addr = f_rw;
        n_rf_w_en   = 1'b1;
        n_alu       = (nxt == S_ADD) ? ALUW'(ALU_ADD) : ALUW'(ALU_SUB);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state          <= S_INIT;
      bus.PC_Clr     <= 1'b0;
      bus.PC_Up      <= 1'b0;
      bus.IR_Ld      <= 1'b0;
      bus.D_Addr     <= '0;
      bus.D_Wr       <= 1'b0;
      bus.RF_s       <= 1'b0;
      bus.RF_W_Addr  <= '0;
      bus.RF_W_En    <= 1'b0;
      bus.RF_Ra_Addr <= '0;
      bus.RF_Rb_Addr <= '0;
      bus.ALU_s0     <= '0;
    end else begin
      state          <= nxt;
      bus.PC_Clr     <= n_pc_clr;
      bus.PC_Up      <= n_pc_up;
      bus.IR_Ld      <= n_ir_ld;
      bus.D_Addr     <= n_d_addr;
      bus.D_Wr       <= n_d_wr;
      bus.RF_s       <= n_rf_s;
      bus.RF_W_Addr  <= n_rf_w_addr;
      bus.RF_W_En    <= n_rf_w_en;
      bus.RF_Ra_Addr <= n_rf_ra;
      bus.RF_Rb_Addr <= n_rf_rb;
      bus.ALU_s0     <= n_alu;
    end
  end

  assign bus.State = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: vector table per instruction plus reset and PC/ROM sequences.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        use_rom = 1'b0;
  logic [15:0] ir_dir = 16'h0000;
  logic [15:0] ir_reg = 16'h0000;
  logic [6:0]  pc = 7'd0;
  logic [15:0] rom [0:127];
  int          checks = 0;
  int          failures = 0;

  control_unit_if #(.DAW(8), .RAW(4), .ALUW(3)) bus ();

  control_unit #(.DAW(8), .RAW(4), .ALUW(3)) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  always_comb bus.IR = use_rom ? ir_reg : ir_dir;

  // Program counter and IR models driven by the unit's controls.
  always @(posedge clk) begin
    if (!bus.PC_Clr) pc <= 7'd0;
    else if (bus.PC_Up) pc <= pc + 7'd1;
    if (bus.IR_Ld) ir_reg <= rom[pc];
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (clr) begin
      chk("inv_dwr_wen", 16'(bus.D_Wr & bus.RF_W_En), 16'h0);
      chk("inv_pcup_fetch", 16'(bus.PC_Up && bus.State != 4'd1), 16'h0);
    end
  end

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  st;
    logic [7:0]  daddr;
    logic [3:0]  ra, rb, rw;
    logic        wen, dwr, rfs;
    logic [2:0]  alu;
  } vec_t;

  vec_t vecs [7];

  task automatic check_outs(input string tag, input vec_t v, input logic wen);
    chk({tag, "_daddr"}, 16'(bus.D_Addr),     16'(v.daddr));
    chk({tag, "_ra"},    16'(bus.RF_Ra_Addr), 16'(v.ra));
    chk({tag, "_rb"},    16'(bus.RF_Rb_Addr), 16'(v.rb));
    chk({tag, "_rw"},    16'(bus.RF_W_Addr),  16'(v.rw));
    chk({tag, "_wen"},   16'(bus.RF_W_En),    16'(wen));
    chk({tag, "_dwr"},   16'(bus.D_Wr),       16'(v.dwr));
    chk({tag, "_rfs"},   16'(bus.RF_s),       16'(v.rfs));
    chk({tag, "_alu"},   16'(bus.ALU_s0),     16'(v.alu));
    chk({tag, "_pcup"},  16'(bus.PC_Up),      16'h0);
    chk({tag, "_pcclr"}, 16'(bus.PC_Clr),     16'h1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, 16'(bus.State),  16'h0);
    chk({tag, "_pcclr"}, 16'(bus.PC_Clr), 16'h0);
    chk({tag, "_en"}, 16'({bus.PC_Up, bus.IR_Ld, bus.D_Wr, bus.RF_W_En, bus.RF_s}), 16'h0);
    chk({tag, "_alu"}, 16'(bus.ALU_s0), 16'h0);
    chk({tag, "_addr"}, 16'({bus.D_Addr, bus.RF_W_Addr, bus.RF_Ra_Addr, bus.RF_Rb_Addr}), 16'h0);
  endtask

  initial begin
    int    pulses;
    int    last_pulse;
    int    cyc;
    bit    halted;
    string tag;

    //        ir        st     daddr  ra    rb    rw    wen   dwr   rfs   alu
    vecs[0] = '{16'h2A35, 4'd3, 8'hA3, 4'h0, 4'h0, 4'h5, 1'b1, 1'b0, 1'b1, 3'b000};
    vecs[1] = '{16'h112F, 4'd5, 8'h12, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 3'b000};
    vecs[2] = '{16'h3126, 4'd6, 8'h00, 4'h1, 4'h2, 4'h6, 1'b1, 1'b0, 1'b0, 3'b001};
    vecs[3] = '{16'h4126, 4'd7, 8'h00, 4'h1, 4'h2, 4'h6, 1'b1, 1'b0, 1'b0, 3'b010};
    vecs[4] = '{16'hF0AB, 4'd8, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[5] = '{16'h0000, 4'd8, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[6] = '{16'h6FFF, 4'd8, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'b000};

    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[5] = 16'h5000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    clr = 1'b1;
    step();
    chk("first_fetch", 16'(bus.State), 16'h1);
    chk("first_fetch_irld", 16'({bus.IR_Ld, bus.PC_Up}), 16'h3);

    // Reset asserted in the middle of an ADD
    ir_dir = 16'h3126;
    step();
    chk("mid_decode", 16'(bus.State), 16'h2);
    step();
    chk("mid_add", 16'(bus.State), 16'h6);
    clr = 1'b0;
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    clr = 1'b1;
    step();
    chk("post_reset_fetch", 16'(bus.State), 16'h1);

    // Table: each instruction from FETCH back to FETCH
    foreach (vecs[i]) begin
      tag = $sformatf("v%0d_%h", i, vecs[i].ir);
      ir_dir = vecs[i].ir;
      step();
      chk({tag, "_decode"}, 16'(bus.State), 16'h2);
      chk({tag, "_decode_en"},
          16'({bus.PC_Up, bus.IR_Ld, bus.D_Wr, bus.RF_W_En, bus.RF_s}), 16'h0);
      step();
      chk({tag, "_exec"}, 16'(bus.State), 16'(vecs[i].st));
      if (vecs[i].st == 4'd3) begin
        check_outs({tag, "_la"}, vecs[i], 1'b0);
        step();
        chk({tag, "_loadb"}, 16'(bus.State), 16'h4);
        check_outs({tag, "_lb"}, vecs[i], vecs[i].wen);
      end else begin
        check_outs(tag, vecs[i], vecs[i].wen);
      end
      step();
      chk({tag, "_refetch"}, 16'(bus.State), 16'h1);
      chk({tag, "_refetch_ctl"}, 16'({bus.IR_Ld, bus.PC_Up, bus.D_Wr, bus.RF_W_En}), 16'hC);
    end

    // PC + ROM: five NOOPs then HALT
    clr = 1'b0;
    use_rom = 1'b1;
    #1;
    check_reset("rom_reset");
    @(negedge clk);
    clr = 1'b1;
    pulses = 0;
    last_pulse = -1;
    halted = 1'b0;
    for (cyc = 0; cyc < 60 && !halted; cyc++) begin
      step();
      if (bus.PC_Up) begin
        if (last_pulse >= 0) chk("pcup_interval", 16'(cyc - last_pulse), 16'd3);
        last_pulse = cyc;
        pulses++;
      end
      if (bus.State == 4'd9) halted = 1'b1;
    end
    chk("halt_reached", 16'(halted), 16'h1);
    chk("halt_pc", 16'(pc), 16'd6);
    chk("halt_pulses", 16'(pulses), 16'd6);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("halt_stay", 16'(bus.State), 16'd9);
      chk("halt_no_pcup", 16'({bus.PC_Up, bus.IR_Ld, bus.D_Wr, bus.RF_W_En}), 16'h0);
    end
    chk("halt_pc_frozen", 16'(pc), 16'd6);
    clr = 1'b0;
    #1;
    check_reset("halt_clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
